// File: rtl/match_ctl.sv
// Penalty-shootout match controller: attributes each resolved kick, keeps the
// running score and kick counts, and decides when the match is over.

package game_pkg;
    typedef enum logic [2:0] {
        START   = 3'd0,
        KEEPER  = 3'd1,
        SHOOTER = 3'd2,
        WINNER  = 3'd3,
        LOSER   = 3'd4
    } g_state;

    typedef enum logic {
        SOLO  = 1'b0,
        MULTI = 1'b1
    } g_mode;
endpackage

module match_ctl
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  g_state     game_state,
    input  g_mode      game_mode,
    input  logic       round_done,
    input  logic       goal,
    output logic       is_shooted,
    output logic       match_end,
    output logic       match_result,
    output logic [3:0] player_score,
    output logic [3:0] enemy_score,
    output logic [3:0] player_kicks,
    output logic [3:0] enemy_kicks
);

    localparam logic [3:0] KICK_MAX   = 4'd15;
    localparam logic [3:0] REG_KICKS  = 4'd5;
    localparam logic [3:0] SOLO_GOALS = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } fsm_t;

    fsm_t       state_q, state_d;
    g_mode      mode_q;
    logic       shot_q;
    logic       result_q;
    logic [3:0] ps_q, es_q, pk_q, ek_q;

    logic       in_round;
    logic       abort;
    logic       accept;
    logic       clear;
    logic       player_kick;
    logic [1:0] verdict;

    // Increment that sticks at the counter ceiling.
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic en);
        logic [3:0] r;
        r = v;
        if (en && (v != KICK_MAX))
            r = v + 4'd1;
        return r;
    endfunction

    // Returns {decided, local_player_won} for the current counters.
    function automatic logic [1:0] judge(
        input g_mode      mode,
        input logic [3:0] ps,
        input logic [3:0] es,
        input logic [3:0] pk,
        input logic [3:0] ek
    );
        logic [4:0] p5, e5, pk5, ek5;
        logic [1:0] v;
        v   = 2'b00;
        p5  = {1'b0, ps};
        e5  = {1'b0, es};
        pk5 = {1'b0, pk};
        ek5 = {1'b0, ek};
        if (mode == SOLO) begin
            if (ps == SOLO_GOALS)
                v = 2'b11;
            else if (es == SOLO_GOALS)
                v = 2'b10;
        end else begin
            // Regulation: a side is out of reach when the other's remaining kicks cannot close the gap.
            if ((pk <= REG_KICKS) && (ek <= REG_KICKS)) begin
                if (p5 > e5 + (5'd5 - ek5))
                    v = 2'b11;
                else if (e5 > p5 + (5'd5 - pk5))
                    v = 2'b10;
            end
            if ((v == 2'b00) && (pk >= REG_KICKS) && (ek >= REG_KICKS) && (pk == ek)) begin
                if (ps > es)
                    v = 2'b11;
                else if (es > ps)
                    v = 2'b10;
                else if (pk == KICK_MAX)
                    v = 2'b10;
            end
        end
        return v;
    endfunction

    assign in_round    = (game_state == KEEPER) || (game_state == SHOOTER);
    assign abort       = (game_state == START);
    assign accept      = (state_q == PLAY) && round_done && in_round;
    assign clear       = (state_d == IDLE);
    assign player_kick = (mode_q == MULTI) && (game_state == SHOOTER);
    assign verdict     = judge(mode_q, ps_q, es_q, pk_q, ek_q);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_round) state_d = PLAY;
            PLAY: begin
                if (abort)
                    state_d = IDLE;
                else if (accept)
                    state_d = EVAL;
            end
            EVAL: begin
                if (abort)
                    state_d = IDLE;
                else if (verdict[1])
                    state_d = DONE;
                else
                    state_d = PLAY;
            end
            DONE: if (abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        is_shooted   = shot_q;
        match_end    = (state_q == DONE);
        match_result = (state_q == DONE) && result_q;
        player_score = ps_q;
        enemy_score  = es_q;
        player_kicks = pk_q;
        enemy_kicks  = ek_q;
    end

    always_ff @(posedge clk) begin
        if (rst)
            mode_q <= SOLO;
        else if ((state_q == IDLE) && (state_d == PLAY))
            mode_q <= game_mode;
    end

    always_ff @(posedge clk) begin
        if (rst)
            shot_q <= 1'b0;
        else
            shot_q <= (state_q == EVAL) && (state_d == PLAY) && (mode_q == MULTI);
    end

    always_ff @(posedge clk) begin
        if (rst || clear)
            result_q <= 1'b0;
        else if ((state_q == EVAL) && (state_d == DONE))
            result_q <= verdict[0];
    end

    // Scores only move together with a kick that was actually counted.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ps_q <= 4'd0;
            es_q <= 4'd0;
            pk_q <= 4'd0;
            ek_q <= 4'd0;
        end else if (accept) begin
            if (player_kick) begin
                pk_q <= sat_inc(pk_q, 1'b1);
                ps_q <= sat_inc(ps_q, goal && (pk_q != KICK_MAX));
            end else begin
                ek_q <= sat_inc(ek_q, 1'b1);
                es_q <= sat_inc(es_q, goal && (ek_q != KICK_MAX));
                if (mode_q == SOLO)
                    ps_q <= sat_inc(ps_q, !goal && (ek_q != KICK_MAX));
            end
        end
    end

endmodule

// File: tb/tb_match_ctl.sv
// Directed bench for match_ctl: a per-cycle reference model plus literal
// expectations for the scripted match scenarios.

module tb_match_ctl;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    g_state     game_state;
    g_mode      game_mode;
    logic       round_done;
    logic       goal;
    logic       is_shooted;
    logic       match_end;
    logic       match_result;
    logic [3:0] player_score, enemy_score, player_kicks, enemy_kicks;

    match_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .game_state   (game_state),
        .game_mode    (game_mode),
        .round_done   (round_done),
        .goal         (goal),
        .is_shooted   (is_shooted),
        .match_end    (match_end),
        .match_result (match_result),
        .player_score (player_score),
        .enemy_score  (enemy_score),
        .player_kicks (player_kicks),
        .enemy_kicks  (enemy_kicks)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int shot_cnt = 0;
    bit cmp_en   = 1'b0;

    // Reference model: match phase flags and plain integer tallies.
    bit m_active, m_eval, m_done, m_multi, m_shot, m_result;
    int mps, mes, mpk, mek;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decide();
        if (!m_multi) begin
            if (mps == 3) return 1;
            if (mes == 3) return 2;
            return 0;
        end
        if (mpk <= 5 && mek <= 5) begin
            if (mps > mes + (5 - mek)) return 1;
            if (mes > mps + (5 - mpk)) return 2;
        end
        if (mpk >= 5 && mek >= 5 && mpk == mek) begin
            if (mps > mes) return 1;
            if (mes > mps) return 2;
            if (mpk == 15) return 2;
        end
        return 0;
    endfunction

    task automatic model_clear();
        m_active = 0; m_eval = 0; m_done = 0; m_shot = 0; m_result = 0;
        mps = 0; mes = 0; mpk = 0; mek = 0;
    endtask

    task automatic model_kick();
        if (m_multi && game_state == SHOOTER) begin
            if (mpk < 15) begin
                mpk++;
                mps += int'(goal);
            end
        end else if (mek < 15) begin
            mek++;
            mes += int'(goal);
            if (!m_multi) mps += int'(!goal);
        end
    endtask

    always @(posedge clk) begin
        bit shot;
        int r;
        shot = 0;
        if (rst) begin
            model_clear();
        end else if (m_done) begin
            if (game_state == START) model_clear();
        end else if (m_eval) begin
            if (game_state == START) begin
                model_clear();
            end else begin
                m_eval = 0;
                r = decide();
                if (r != 0) begin
                    m_done = 1;
                    m_result = (r == 1);
                end else if (m_multi) begin
                    shot = 1;
                end
            end
        end else if (m_active) begin
            if (game_state == START)
                model_clear();
            else if (round_done && (game_state == KEEPER || game_state == SHOOTER)) begin
                model_kick();
                m_eval = 1;
            end
        end else if (game_state == KEEPER || game_state == SHOOTER) begin
            m_active = 1;
            m_multi  = (game_mode == MULTI);
        end
        m_shot = shot;
    end

    always @(negedge clk) begin
        logic [18:0] act, exp;
        if (cmp_en) begin
            act = {is_shooted, match_end, match_result,
                   player_score, enemy_score, player_kicks, enemy_kicks};
            exp = {m_shot, m_done, m_done & m_result,
                   4'(mps), 4'(mes), 4'(mpk), 4'(mek)};
            chk("cycle_outputs", int'(act), int'(exp));
            if (is_shooted === 1'b1) shot_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic kick(input g_state gs, input logic g);
        game_state = gs;
        goal       = g;
        round_done = 1'b1;
        tick();
        round_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic start_match(input g_mode m, input g_state gs);
        game_mode  = m;
        game_state = gs;
        tick();
        tick();
    endtask

    task automatic to_idle();
        game_state = START;
        round_done = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int s0;
        rst = 1'b1; game_state = START; game_mode = SOLO; round_done = 1'b0; goal = 1'b0;
        tick();
        tick();
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_match_end", int'(match_end), 0);
        chk("rst_is_shooted", int'(is_shooted), 0);
        chk("rst_scores", int'({player_score, enemy_score, player_kicks, enemy_kicks}), 0);
        tick();
        rst = 1'b0;
        tick();

        // SOLO: three saves win the match
        s0 = shot_cnt;
        start_match(SOLO, KEEPER);
        kick(KEEPER, 1'b0);
        kick(KEEPER, 1'b0);
        game_state = KEEPER; goal = 1'b0; round_done = 1'b1;
        tick();
        round_done = 1'b0;
        @(negedge clk);
        chk("solo_win_score_n1", int'(player_score), 3);
        chk("solo_win_end_n1", int'(match_end), 0);
        tick();
        @(negedge clk);
        chk("solo_win_end_n2", int'(match_end), 1);
        chk("solo_win_result", int'(match_result), 1);
        chk("solo_win_enemy_kicks", int'(enemy_kicks), 3);
        chk("solo_no_shot", shot_cnt - s0, 0);
        to_idle();

        // MULTI: 3-0 after six kicks; mode change mid-match is ignored
        s0 = shot_cnt;
        start_match(MULTI, SHOOTER);
        game_mode = SOLO;
        for (int i = 0; i < 3; i++) begin
            kick(SHOOTER, 1'b1);
            kick(KEEPER, 1'b0);
        end
        @(negedge clk);
        chk("multi_30_end", int'(match_end), 1);
        chk("multi_30_result", int'(match_result), 1);
        chk("multi_30_score", int'({player_score, enemy_score}), 8'h30);
        chk("multi_30_shots", shot_cnt - s0, 5);
        to_idle();

        // MULTI: 4-4 after regulation, sudden death won by the player
        start_match(MULTI, SHOOTER);
        for (int i = 0; i < 4; i++) begin
            kick(SHOOTER, 1'b1);
            kick(KEEPER, 1'b1);
        end
        kick(SHOOTER, 1'b0);
        kick(KEEPER, 1'b0);
        @(negedge clk);
        chk("sd_44_open", int'(match_end), 0);
        kick(SHOOTER, 1'b1);
        @(negedge clk);
        chk("sd_unequal_kicks_open", int'(match_end), 0);
        kick(KEEPER, 1'b0);
        @(negedge clk);
        chk("sd_end", int'(match_end), 1);
        chk("sd_result", int'(match_result), 1);
        chk("sd_kicks", int'({player_kicks, enemy_kicks}), 8'h66);
        chk("sd_score", int'({player_score, enemy_score}), 8'h54);
        to_idle();

        // MULTI: round_done held two cycles counts once; then abort at 2-1
        start_match(MULTI, SHOOTER);
        game_state = SHOOTER; goal = 1'b1; round_done = 1'b1;
        tick();
        @(negedge clk);
        chk("dbl_eval_no_shot", int'(is_shooted), 0);
        tick();
        round_done = 1'b0;
        @(negedge clk);
        chk("dbl_shot_n2", int'(is_shooted), 1);
        chk("dbl_kicks", int'(player_kicks), 1);
        tick();
        @(negedge clk);
        chk("dbl_shot_n3", int'(is_shooted), 0);
        kick(KEEPER, 1'b1);
        kick(SHOOTER, 1'b1);
        @(negedge clk);
        chk("abort_pre_score", int'({player_score, enemy_score}), 8'h21);
        game_state = START;
        tick();
        @(negedge clk);
        chk("abort_counters", int'({player_score, enemy_score, player_kicks, enemy_kicks}), 0);
        chk("abort_match_end", int'(match_end), 0);
        tick();

        // SOLO loss, held in DONE for 20 cycles, then released by START
        start_match(SOLO, KEEPER);
        kick(KEEPER, 1'b1);
        kick(KEEPER, 1'b1);
        kick(KEEPER, 1'b1);
        game_state = LOSER;
        repeat (20) tick();
        @(negedge clk);
        chk("loss_hold_end", int'(match_end), 1);
        chk("loss_hold_result", int'(match_result), 0);
        chk("loss_hold_score", int'({player_score, enemy_score, enemy_kicks}), 12'h033);
        game_state = START;
        tick();
        @(negedge clk);
        chk("loss_release_end", int'(match_end), 0);
        tick();

        // MULTI: every kick scores until the 15/15 cap
        start_match(MULTI, SHOOTER);
        for (int i = 0; i < 15; i++) begin
            kick(SHOOTER, 1'b1);
            kick(KEEPER, 1'b1);
        end
        @(negedge clk);
        chk("cap_end", int'(match_end), 1);
        chk("cap_result", int'(match_result), 0);
        chk("cap_counts", int'({player_score, enemy_score, player_kicks, enemy_kicks}), 16'hffff);
        to_idle();

        // START during EVAL: no pulse, counters cleared
        start_match(MULTI, SHOOTER);
        game_state = SHOOTER; goal = 1'b1; round_done = 1'b1;
        tick();
        game_state = START; round_done = 1'b0;
        tick();
        @(negedge clk);
        chk("eval_abort_shot", int'(is_shooted), 0);
        chk("eval_abort_kicks", int'(player_kicks), 0);
        tick();

        // Reset mid-match discards it and emits nothing afterwards
        start_match(MULTI, SHOOTER);
        kick(SHOOTER, 1'b1);
        game_state = KEEPER; goal = 1'b1; round_done = 1'b1;
        tick();
        rst = 1'b1; round_done = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_counters", int'({player_score, enemy_score, player_kicks, enemy_kicks}), 0);
        tick();
        @(negedge clk);
        chk("rst_mid_no_pulse", int'({is_shooted, match_end}), 0);
        to_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
